// File: rtl/vga_text_pkg.sv
// Shared state encoding and byte constants for the VGA text line buffer.
package vga_text_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

endpackage

// File: rtl/vga_char_decode.sv
// Combinational byte classifier; exactly one of the four outputs is high for any byte.
module vga_char_decode
  import vga_text_pkg::*;
(
  input  logic [7:0] char_data,
  output logic       is_print,
  output logic       is_bs,
  output logic       is_clear,
  output logic       is_other
);

  always_comb begin
    is_print = (char_data >= CH_PRINT_LO) && (char_data <= CH_PRINT_HI);
    is_bs    = (char_data == CH_BS);
    is_clear = (char_data == CH_LF) || (char_data == CH_FF);
    is_other = !(is_print || is_bs || is_clear);
  end

endmodule

// File: rtl/vga_text_buffer.sv
// Character line buffer feeding the VGA text display from a valid/ready byte stream.
// Define VGA_TEXT_SCROLL_EN to scroll left on a printable byte when the line is full.
//
// state | meaning
// IDLE  | accepting bytes, char_ready high
// CLEAR | blanking one cell per cycle after LF/FF, char_ready low
module vga_text_buffer
  import vga_text_pkg::*;
#(
  parameter int         N_CHARS = 36,
  parameter logic [7:0] BLANK   = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   char_valid,
  input  logic [7:0]             char_data,
  output logic                   char_ready,
  output logic [8*N_CHARS-1:0]   cells,
  output logic [5:0]             cursor,
  output logic                   full
);

  localparam logic [5:0] CURSOR_MAX = 6'(N_CHARS);
  localparam logic [5:0] LAST_IDX   = 6'(N_CHARS - 1);

  state_e     state_q, state_d;
  logic [7:0] cells_q [N_CHARS];
  logic [7:0] cells_d [N_CHARS];
  logic [5:0] cursor_q, cursor_d;
  logic [5:0] clr_idx_q, clr_idx_d;
  logic       full_q, full_d;

  logic is_print, is_bs, is_clear, is_other;

  vga_char_decode u_decode (
    .char_data (char_data),
    .is_print  (is_print),
    .is_bs     (is_bs),
    .is_clear  (is_clear),
    .is_other  (is_other)
  );

  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    cursor_d  = cursor_q;
    clr_idx_d = clr_idx_q;

    case (state_q)
      IDLE: begin
        // Unrecognised bytes are still accepted (ready is high) but change nothing.
        if (char_valid && !is_other) begin
          if (is_print) begin
            if (cursor_q < CURSOR_MAX) begin
              cells_d[cursor_q] = char_data;
              cursor_d          = cursor_q + 6'd1;
            end else begin
`ifdef VGA_TEXT_SCROLL_EN
              for (int i = 0; i < N_CHARS - 1; i++) begin
                cells_d[i] = cells_q[i+1];
              end
              cells_d[N_CHARS-1] = char_data;
`endif
            end
          end else if (is_bs) begin
            if (cursor_q != 6'd0) begin
              cursor_d                   = cursor_q - 6'd1;
              cells_d[cursor_q - 6'd1]   = BLANK;
            end
          end else if (is_clear) begin
            cursor_d  = 6'd0;
            clr_idx_d = 6'd0;
            state_d   = CLEAR;
          end
        end
      end
      CLEAR: begin
        cells_d[clr_idx_q] = BLANK;
        clr_idx_d          = clr_idx_q + 6'd1;
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = 6'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full_d = (cursor_d == CURSOR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cursor_q  <= 6'd0;
      clr_idx_q <= 6'd0;
      full_q    <= 1'b0;
      for (int i = 0; i < N_CHARS; i++) begin
        cells_q[i] <= BLANK;
      end
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      clr_idx_q <= clr_idx_d;
      full_q    <= full_d;
      cells_q   <= cells_d;
    end
  end

  for (genvar g = 0; g < N_CHARS; g++) begin : g_cells
    assign cells[8*g +: 8] = cells_q[g];
  end

  assign char_ready = (state_q == IDLE);
  assign cursor     = cursor_q;
  assign full       = full_q;

endmodule
